dcm_clkgen: RTL and testbench
=============================

Name: dcm_clkgen

Overview:
- Digital clock generator. Derives two 50%-duty (or near) output clocks from one input clock by integer division, plus a LOCKED status flag.
- Sits at the top of the FPGA clock tree. Default use: 200 MHz in -> CLK_OUT1 40 MHz (I2C/control domain), CLK_OUT2 100 MHz (DDS/pixel domain).
- Both outputs start phase-aligned after lock. Each output is a registered fabric signal; the integrator routes it through a global buffer.

Parameters:
- DIV1, 5: CLK_OUT1 divide ratio. Integer, must be >=2; elaboration error otherwise.
- DIV2, 2: CLK_OUT2 divide ratio. Integer, must be >=2; elaboration error otherwise.
- LOCK_CYCLES, 16: input-clock cycles after reset release before LOCKED asserts. Must be >=1. Used only with DCM_LOCK_DELAY_EN.
- CNT_W, 8: width of divider counters. Must satisfy 2^CNT_W >= max(DIV1, DIV2, LOCK_CYCLES); elaboration error otherwise.

Ports:
- CLK_IN1, in, 1: reference input clock. This is the only clock; all logic is on its rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- CLK_OUT1, out, 1: input clock divided by DIV1.
- CLK_OUT2, out, 1: input clock divided by DIV2.
- LOCKED, out, 1: high once the outputs are running.

Behaviour:
- Reset (asynchronous): CLK_OUT1=0, CLK_OUT2=0, LOCKED=0, lock counter=0, cnt1=DIV1-1, cnt2=DIV2-1.
- Reset asserted mid-operation: all outputs drop low immediately, without waiting for a clock edge.
- Lock counter: after reset release, increments on each CLK_IN1 rising edge. LOCKED registers to 1 on the LOCK_CYCLES-th rising edge after release. After that, LOCKED is sticky until the next RESET.
- run = LOCKED.
- Divider k (k = 1 or 2), while run=0: cnt_k held at DIVk-1, CLK_OUTk held at 0.
- Divider k, while run=1, on each edge:
  - cnt_k <= (cnt_k == DIVk-1) ? 0 : cnt_k+1
  - CLK_OUTk <= (next cnt_k < HIGHk), where HIGHk = ceil(DIVk/2)
- Odd DIVk: high for ceil(DIVk/2) cycles, low for floor(DIVk/2) cycles. Even DIVk: exact 50% duty.
- Start-up: the first rising edge of both outputs occurs on the same input edge, one edge after LOCKED rises. Rising edges coincide again every lcm(DIV1, DIV2) input cycles.
- Outputs are glitch-free: each is a single flop, so it changes at most once per input cycle.
- Counter wrap-around is exact. There is no drift or accumulated error.

Optional Feature:
- Macro: DCM_LOCK_DELAY_EN.
- Defined: lock counter present; LOCKED rises on the LOCK_CYCLES-th edge after reset release, as above.
- Undefined: no lock counter. LOCKED registers to 1 on the first edge after reset release (equivalent to LOCK_CYCLES=1). LOCK_CYCLES is ignored.

Decomposition:
- Shared package dcm_clkgen_pkg: a function returning ceil(n/2) and a function returning the minimum counter width for a value; parameter-legality checks use these.
- Natural sub-module: clk_div_even_odd, a single divider with parameter DIV and ports clk, rst, run, clk_out. It is instantiated twice.

Test Plan:
- Defaults, macro on; RESET held for 3 cycles, then released:
  - LOCKED=0 for edges 1-15 and 1 on edge 16.
  - CLK_OUT1 and CLK_OUT2 both rise first on edge 17.
- Steady state, DIV1=5: CLK_OUT1 pattern 1,1,1,0,0 repeating (period 5, high 3).
- Steady state, DIV2=2: CLK_OUT2 pattern 1,0 (period 2). Rising edges of both outputs coincide every 10 input cycles.
- RESET asserted asynchronously between edges while running: outputs and LOCKED go to 0 before the next edge. After release, the start-up sequence repeats identically.
- DIV1=4, DIV2=3, macro off:
  - LOCKED=1 on edge 1 and both outputs rise on edge 2.
  - CLK_OUT1 pattern 1,1,0,0; CLK_OUT2 pattern 1,1,0.
- Run 10,000 input cycles: count rising edges; expect exactly floor(cycles/DIVk) ± 1 per output, with no glitches (never more than one transition per input cycle).

Source files
------------

// File: rtl/dcm_clkgen_pkg.sv
// Shared helpers for the dcm_clkgen clock generator.
// Holds the sizing functions used by the parameter legality checks.
package dcm_clkgen_pkg;

    localparam int DCM_MIN_DIV = 2;
    localparam int DCM_MIN_LOCK = 1;

    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

    // Smallest width w (at least 1) such that 2^w >= v.
    function automatic int cnt_width(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w++;
        end
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/dcm_clkgen_div.sv
// Single integer divider: 50% duty for even DIV, high-biased for odd DIV.
// Output is one flop, so it changes at most once per input cycle.
import dcm_clkgen_pkg::*;

module clk_div_even_odd #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic clk_out
);

    localparam int W = cnt_width(DIV);
    localparam int HIGH = ceil_half(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HI = W'(HIGH);

    if (DIV < DCM_MIN_DIV) begin : g_bad_div
        $error("clk_div_even_odd: DIV must be >= 2");
    end

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_next;
    logic         r_out;

    always_comb begin
        w_next = (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end

    // Parked at LAST so the first running edge wraps to 0 and rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= LAST;
            r_out <= 1'b0;
        end else if (!run) begin
            r_cnt <= LAST;
            r_out <= 1'b0;
        end else begin
            r_cnt <= w_next;
            r_out <= (w_next < HI);
        end
    end

    assign clk_out = r_out;

endmodule

// File: rtl/dcm_clkgen.sv
// Two-output integer clock divider with LOCKED status.
// Define DCM_LOCK_DELAY_EN to delay LOCKED by LOCK_CYCLES input edges.
import dcm_clkgen_pkg::*;

module dcm_clkgen #(
    parameter int DIV1        = 5,
    parameter int DIV2        = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic CLK_IN1,
    input  logic RESET,
    output logic CLK_OUT1,
    output logic CLK_OUT2,
    output logic LOCKED
);

    if (DIV1 < DCM_MIN_DIV) begin : g_bad_div1
        $error("dcm_clkgen: DIV1 must be >= 2");
    end
    if (DIV2 < DCM_MIN_DIV) begin : g_bad_div2
        $error("dcm_clkgen: DIV2 must be >= 2");
    end
    if (LOCK_CYCLES < DCM_MIN_LOCK) begin : g_bad_lock
        $error("dcm_clkgen: LOCK_CYCLES must be >= 1");
    end
    if (CNT_W < cnt_width(max3(DIV1, DIV2, LOCK_CYCLES))) begin : g_bad_w
        $error("dcm_clkgen: CNT_W too narrow");
    end

    logic r_locked;
    logic w_out1;
    logic w_out2;

`ifdef DCM_LOCK_DELAY_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [CNT_W-1:0] r_lock_cnt;

    // Counter freezes once locked; LOCKED stays set until RESET.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            if (r_lock_cnt == LOCK_LAST) begin
                r_locked <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            r_locked <= 1'b0;
        end else begin
            r_locked <= 1'b1;
        end
    end
`endif

    clk_div_even_odd #(
        .DIV (DIV1)
    ) u_div1 (
        .clk     (CLK_IN1),
        .rst     (RESET),
        .run     (r_locked),
        .clk_out (w_out1)
    );

    clk_div_even_odd #(
        .DIV (DIV2)
    ) u_div2 (
        .clk     (CLK_IN1),
        .rst     (RESET),
        .run     (r_locked),
        .clk_out (w_out2)
    );

    assign CLK_OUT1 = w_out1;
    assign CLK_OUT2 = w_out2;
    assign LOCKED   = r_locked;

endmodule

// File: tb/tb_dcm_clkgen.sv
// Self-checking bench for dcm_clkgen: default build and a 4/3 divider build.
// Expected waveforms come from edge-index arithmetic, not from the RTL structure.
module tb_dcm_clkgen;

    localparam int DA1 = 5;
    localparam int DA2 = 2;
    localparam int DB1 = 4;
    localparam int DB2 = 3;
`ifdef DCM_LOCK_DELAY_EN
    localparam int LA = 16;
    localparam int LB = 7;
`else
    localparam int LA = 1;
    localparam int LB = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o1a, o2a, lka;
    logic o1b, o2b, lkb;

    int n_assert = 0;
    int n_fail = 0;
    int n = 0;

    int tg1a = 0, tg2a = 0, tg1b = 0, tg2b = 0;
    int p1a = 0, p2a = 0, p1b = 0, p2b = 0;

    dcm_clkgen u_a (
        .CLK_IN1  (clk),
        .RESET    (rst),
        .CLK_OUT1 (o1a),
        .CLK_OUT2 (o2a),
        .LOCKED   (lka)
    );

    dcm_clkgen #(
        .DIV1        (DB1),
        .DIV2        (DB2),
        .LOCK_CYCLES (LB),
        .CNT_W       (4)
    ) u_b (
        .CLK_IN1  (clk),
        .RESET    (rst),
        .CLK_OUT1 (o1b),
        .CLK_OUT2 (o2b),
        .LOCKED   (lkb)
    );

    always #5 clk = ~clk;

    always @(o1a) tg1a++;
    always @(o2a) tg2a++;
    always @(o1b) tg1b++;
    always @(o2b) tg2b++;

    // Edge k after release: locked from edge L; output runs from edge L+1
    // with phase m = k-L-1, high while m mod div < ceil(div/2).
    function automatic logic m_lock(input int k, input int l);
        return (k >= l);
    endfunction

    function automatic logic m_out(input int k, input int l, input int div);
        if (k <= l) begin
            return 1'b0;
        end
        return (((k - l - 1) % div) < ((div + 1) / 2));
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lka"}, lka, 1'b0);
        chk({tag, "_o1a"}, o1a, 1'b0);
        chk({tag, "_o2a"}, o2a, 1'b0);
        chk({tag, "_lkb"}, lkb, 1'b0);
        chk({tag, "_o1b"}, o1b, 1'b0);
        chk({tag, "_o2b"}, o2b, 1'b0);
    endtask

    task automatic sync_tog();
        p1a = tg1a;
        p2a = tg2a;
        p1b = tg1b;
        p2b = tg2b;
    endtask

    task automatic hold_reset(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        sync_tog();
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        n++;
        chk("lock_a", lka, m_lock(n, LA));
        chk("out1_a", o1a, m_out(n, LA, DA1));
        chk("out2_a", o2a, m_out(n, LA, DA2));
        chk("lock_b", lkb, m_lock(n, LB));
        chk("out1_b", o1b, m_out(n, LB, DB1));
        chk("out2_b", o2b, m_out(n, LB, DB2));
        chk("glitch_1a", (tg1a - p1a) <= 1, 1'b1);
        chk("glitch_2a", (tg2a - p2a) <= 1, 1'b1);
        chk("glitch_1b", (tg1b - p1b) <= 1, 1'b1);
        chk("glitch_2b", (tg2b - p2b) <= 1, 1'b1);
        sync_tog();
    endtask

    initial begin
        int d;
        int r1a, r2a, r1b, r2b;
        logic q1a, q2a, q1b, q2b;

        rst = 1'b1;
        #1;
        chk_zero("reset_state");
        hold_reset(3);
        repeat (60) sample();

        for (int ep = 0; ep < 3; ep++) begin
            @(negedge clk);
            d = $urandom_range(1, 3);
            #(d);
            rst = 1'b1;
            #1;
            chk_zero("async_rst");
            hold_reset($urandom_range(1, 4));
            repeat ($urandom_range(30, 80)) sample();
        end

        r1a = 0;
        r2a = 0;
        r1b = 0;
        r2b = 0;
        q1a = o1a;
        q2a = o2a;
        q1b = o1b;
        q2b = o2b;
        for (int c = 0; c < 10000; c++) begin
            sample();
            if (o1a && !q1a) r1a++;
            if (o2a && !q2a) r2a++;
            if (o1b && !q1b) r1b++;
            if (o2b && !q2b) r2b++;
            q1a = o1a;
            q2a = o2a;
            q1b = o1b;
            q2b = o2b;
        end
        chk_rng("rises_1a", r1a, 10000 / DA1 - 1, 10000 / DA1 + 1);
        chk_rng("rises_2a", r2a, 10000 / DA2 - 1, 10000 / DA2 + 1);
        chk_rng("rises_1b", r1b, 10000 / DB1 - 1, 10000 / DB1 + 1);
        chk_rng("rises_2b", r2b, 10000 / DB2 - 1, 10000 / DB2 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
